data_sram_bridge: RTL

Downstream neighbour of the five-stage datapath's MEM stage: converts the single-cycle data-SRAM port (address, byte-write mask, write data, read data) into a split-transaction SRAM-like bus with `addr_ok`/`data_ok` handshakes. It issues one access at a time, holds the pipeline through a `stall` output until the access completes, and latches read data for the MEM/WB register. Byte-enable masks use the datapath's big-endian lane numbering: mask bit 3 is byte offset 0.

---
 rtl/data_sram_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Converts the MEM stage's single-cycle data-SRAM port into a split-transaction
//   SRAM-like bus (addr_ok / data_ok). One access in flight at a time; the
//   pipeline is held through `stall` until the bus returns data, and the
//   returned word is latched for the MEM/WB register.
//
//   Optional feature macro: BRIDGE_ADDR_MAP_EN
//     defined   : data_addr clears the top three bits for kseg0/kseg1
//                 (addr[31:29] == 3'b100 or 3'b101)
//     undefined : data_addr is the latched address, word-aligned for word size
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   mem_en/wen/size/addr/wdata  MEM stage request (wen==0 -> load, lane mask
//                               is big-endian: bit 3 = byte offset 0)
//   pipe_stall             other stall source; holds DONE
//   mem_rdata              latched bus read data
//   stall                  freeze IF..MEM
//   addr_err               misaligned / illegal-size pulse
//   data_*                 split-transaction bus master side
module data_sram_bridge #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en,
   input  logic [3:0]        mem_wen,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [ADDR_W-1:0] mem_wdata,
   input  logic              pipe_stall,
   output logic [ADDR_W-1:0] mem_rdata,
   output logic              stall,
   output logic              addr_err,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [ADDR_W-1:0] data_wdata,
   output logic [3:0]        data_wstrb,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [ADDR_W-1:0] data_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wen_q, wen_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] rdata_q, rdata_d;
   logic              aligned;
   logic [ADDR_W-1:0] bus_addr;

   // Size 3 is illegal and lands in the default arm, so it is reported the
   // same way as a misaligned access.
   always_comb begin
      aligned = 1'b0;
      case (mem_size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~mem_addr[0];
         2'd2:    aligned = (mem_addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wen_d    = wen_q;
      size_d   = size_q;
      rdata_d  = rdata_q;
      stall    = 1'b0;
      addr_err = 1'b0;
      data_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_en) begin
               if (aligned) begin
                  addr_d  = mem_addr;
                  wdata_d = mem_wdata;
                  wen_d   = mem_wen;
                  size_d  = mem_size;
                  stall   = 1'b1;
                  state_d = REQ;
               end else begin
                  addr_err = 1'b1;
               end
            end
         end
         REQ: begin
            data_req = 1'b1;
            stall    = 1'b1;
            if (data_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            // Stores capture too; the value is simply never consumed.
            if (data_data_ok) begin
               rdata_d = data_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            // The instruction is still in MEM while pipe_stall holds; leaving
            // DONE only when MEM advances prevents a second issue.
            if (!pipe_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus_addr = addr_q;
      if (size_q == 2'd2) bus_addr[1:0] = 2'b00;
`ifdef BRIDGE_ADDR_MAP_EN
      // kseg0 / kseg1 both alias the low 512 MB of physical space.
      if (bus_addr[ADDR_W-1 -: 2] == 2'b10) bus_addr[ADDR_W-1 -: 3] = 3'b000;
`endif
   end

   assign data_addr  = bus_addr;
   assign data_wr    = |wen_q;
   assign data_wstrb = wen_q;
   assign data_size  = size_q;
   assign data_wdata = wdata_q;
   assign mem_rdata  = rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= '0;
         size_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
